// File: rtl/fetch.sv
// Instruction fetch stage: issues one word-aligned request at a time to the
// instruction memory, delivers responses into the IF/ID register, buffers a
// single response behind a decode stall, and drops responses that a
// branch/jump redirect has made stale.
// Optional build macro FETCH_STALL_CNT_EN adds the stall_cycles output, a
// saturating count of cycles where decode stalls on a valid instruction.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_instru,
    output logic [31:0] if_pc,
    output logic        if_valid
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        discard_r;
    logic        discard_nxt_s;
    logic [31:0] fetch_pc_r;
    logic [31:0] req_pc_r;
    logic [31:0] buf_instr_r;
    logic        handshake_s;
    logic        load_rsp_s;
    logic        load_buf_s;
    logic        cap_buf_s;
    logic        redirect_unused_s;

    // Redirect targets are forced to word alignment, so the low bits are ignored.
    assign redirect_unused_s = &redirect_pc[1:0];

    // A redirect suppresses the request so that no stale address is accepted
    // in the same cycle the new target is loaded.
    assign imem_req    = rst_n && (state_r == ST_REQ) && !flush;
    assign imem_addr   = fetch_pc_r;
    assign handshake_s = imem_req && imem_ready;

    // Next-state, discard flag and IF/ID load selection.
    always_comb begin
        state_nxt_s   = state_r;
        discard_nxt_s = discard_r;
        load_rsp_s    = 1'b0;
        load_buf_s    = 1'b0;
        cap_buf_s     = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (flush) begin
                    state_nxt_s = ST_REQ;
                end else if (handshake_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    // The outstanding response has arrived; any discard obligation is met.
                    discard_nxt_s = 1'b0;
                    if (flush || discard_r) begin
                        state_nxt_s = ST_REQ;
                    end else if (stall) begin
                        state_nxt_s = ST_HOLD;
                        cap_buf_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_REQ;
                        load_rsp_s  = 1'b1;
                    end
                end else if (flush) begin
                    // Keep waiting: the stale response must be absorbed before a new request.
                    discard_nxt_s = 1'b1;
                    state_nxt_s   = ST_WAIT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_nxt_s = ST_REQ;
                end else if (!stall) begin
                    state_nxt_s = ST_REQ;
                    load_buf_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s   = ST_REQ;
                discard_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state and discard flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_REQ;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            discard_r <= discard_nxt_s;
        end
    end

    // Fetch PC advance/redirect and PC of the outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= 32'h0000_0000;
        end else if (flush) begin
            fetch_pc_r <= {redirect_pc[31:2], 2'b00};
            req_pc_r   <= req_pc_r;
        end else if (handshake_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
            req_pc_r   <= fetch_pc_r;
        end else begin
            fetch_pc_r <= fetch_pc_r;
            req_pc_r   <= req_pc_r;
        end
    end

    // One-entry buffer for a response that arrives while decode is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_instr_r <= NOP_INSTR;
        end else if (cap_buf_s) begin
            buf_instr_r <= imem_rdata;
        end else begin
            buf_instr_r <= buf_instr_r;
        end
    end

    // IF/ID register: flush bubbles, stall holds, otherwise load or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid  <= 1'b0;
            if_instru <= NOP_INSTR;
            if_pc     <= 32'h0000_0000;
        end else if (flush) begin
            if_valid  <= 1'b0;
            if_instru <= NOP_INSTR;
            if_pc     <= if_pc;
        end else if (stall) begin
            if_valid  <= if_valid;
            if_instru <= if_instru;
            if_pc     <= if_pc;
        end else if (load_rsp_s) begin
            if_valid  <= 1'b1;
            if_instru <= imem_rdata;
            if_pc     <= req_pc_r;
        end else if (load_buf_s) begin
            if_valid  <= 1'b1;
            if_instru <= buf_instr_r;
            if_pc     <= req_pc_r;
        end else begin
            // Decode consumed the previous instruction and nothing new is ready.
            if_valid  <= 1'b0;
            if_instru <= NOP_INSTR;
            if_pc     <= if_pc;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of cycles where decode stalls on a valid instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'h0000_0000;
        end else if (stall && if_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end else begin
            stall_cycles <= stall_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios followed by randomized stall/flush/
// ready/latency traffic, checked against a transaction-level model (queue of
// accepted fetch addresses, expected next fetch PC, memory contents as a
// function of address). A second instance with RESET_PC at the top of the
// address space runs free to exercise PC wrap.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] if_instru;
    logic [31:0] if_pc;
    logic        if_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic [31:0] w_if_instru;
    logic [31:0] w_if_pc;
    logic        w_if_valid;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] w_stall_cycles;
    logic [31:0] model_cnt = 32'h0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          deliveries = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = 32'h0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic        stray = 1'b0;
    logic        last_st = 1'b0;
    logic        last_fl = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_instru = 32'h0;
    logic [31:0] prev_pc = 32'h0;
    logic        prev_req_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] w_model_pc = 32'hFFFF_FFFC;
    logic        w_pend = 1'b0;
    logic [31:0] w_paddr = 32'h0;

    always #5 clk = ~clk;

    fetch u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .if_instru(if_instru), .if_pc(if_pc), .if_valid(if_valid)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .stall(1'b0), .flush(1'b0), .redirect_pc(32'h0),
        .if_instru(w_if_instru), .if_pc(w_if_pc), .if_valid(w_if_valid)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cycles(w_stall_cycles)
`endif
    );

    // Memory contents: two fixed words used by the directed scenarios, a
    // scrambled function of the address everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] r;
        if (a == 32'h0000_0000) r = 32'h0050_0093;
        else if (a == 32'h0000_0008) r = 32'h0000_0113;
        else r = {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; w_rvalid = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instru, NOP);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_wrap_req", {31'd0, w_req}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        model_cnt = 32'h0;
`endif
        @(posedge clk);
        #1;
        chk("rst_hold_req", {31'd0, imem_req}, 32'd0);
        exp_q.delete();
        model_pc = 32'h0; pend = 1'b0; cnt = 0;
        last_st = 1'b0; last_fl = 1'b0; prev_req_wait = 1'b0;
        w_model_pc = 32'hFFFF_FFFC; w_pend = 1'b0;
        rst_n = 1'b1;
    endtask

    // One clock: check what the last edge produced, drive inputs, advance the model.
    task automatic cycle(input logic st, input logic fl, input logic [31:0] rd, input logic rdy);
        logic hs;
        @(negedge clk);
        if (last_fl) begin
            chk("flush_valid", {31'd0, if_valid}, 32'd0);
            chk("flush_nop", if_instru, NOP);
        end else if (last_st) begin
            chk("stall_valid", {31'd0, if_valid}, {31'd0, prev_valid});
            chk("stall_instr", if_instru, prev_instru);
            chk("stall_pc", if_pc, prev_pc);
        end else if (if_valid) begin
            deliveries++;
            chk("deliver_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                chk("deliver_pc", if_pc, exp_q[0]);
                void'(exp_q.pop_front());
            end
            chk("deliver_instr", if_instru, mem_word(if_pc));
        end
        if (!if_valid) chk("bubble_nop", if_instru, NOP);
        if (w_if_valid) chk("wrap_instr", w_if_instru, mem_word(w_if_pc));
        else chk("wrap_nop", w_if_instru, NOP);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, model_cnt);
        chk("wrap_stall_cycles", w_stall_cycles, 32'd0);
`endif
        prev_valid = if_valid; prev_instru = if_instru; prev_pc = if_pc;

        stall = st; flush = fl; redirect_pc = rd; imem_ready = rdy;
        if (pend && cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = mem_word(paddr);
        end else begin
            if (pend) cnt--;
            imem_rvalid = stray && !pend;
            imem_rdata = $urandom;
        end
        w_rvalid = w_pend;
        w_rdata = w_pend ? mem_word(w_paddr) : 32'h0;
        stray = 1'b0;
        #1;
        if (prev_req_wait && imem_req) chk("addr_stable", imem_addr, prev_addr);
        if (imem_req) chk("one_outstanding", {31'd0, pend}, 32'd0);
        hs = imem_req && imem_ready;
        if (imem_rvalid) pend = 1'b0;
        if (hs) begin
            chk("req_addr", imem_addr, model_pc);
            if (!fl) exp_q.push_back(imem_addr);
            model_pc = model_pc + 32'd4;
            pend = 1'b1;
            paddr = imem_addr;
            cnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
        end
        if (fl) begin
            exp_q.delete();
            model_pc = {rd[31:2], 2'b00};
        end
        prev_req_wait = imem_req && !imem_ready && !fl;
        prev_addr = imem_addr;
        last_st = st; last_fl = fl;
        if (w_rvalid) w_pend = 1'b0;
        if (w_req) begin
            chk("wrap_one_outstanding", {31'd0, w_pend}, 32'd0);
            chk("wrap_addr", w_addr, w_model_pc);
            w_model_pc = w_model_pc + 32'd4;
            w_pend = 1'b1;
            w_paddr = w_addr;
        end
`ifdef FETCH_STALL_CNT_EN
        if (st && if_valid && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
`endif
    endtask

    initial begin
        int n;
        do_reset();

        // First fetch from RESET_PC with a one-cycle memory.
        lat_lo = 1; lat_hi = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("first_valid", {31'd0, if_valid}, 32'd1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instru, 32'h0050_0093);
        chk("second_addr", imem_addr, 32'h4);
        chk("wrap_second_addr", w_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Response for PC 8 arrives while decode stalls for three cycles.
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_prior_pc", if_pc, 32'h4);
        chk("stall_prior_valid", {31'd0, if_valid}, 32'd1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("after_stall_pc", if_pc, 32'h8);
        chk("after_stall_instr", if_instru, 32'h0000_0113);

        // Five stall cycles on a valid instruction (three earlier ones counted too).
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        lat_lo = 3; lat_hi = 3;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cycles_total", stall_cycles, 32'd8);
`endif

        // Redirect while the request for PC 12 is outstanding.
        cycle(1'b0, 1'b1, 32'h0000_0102, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("flush_if_valid", {31'd0, if_valid}, 32'd0);
        chk("flush_if_instr", if_instru, NOP);
        chk("flush_no_req", {31'd0, imem_req}, 32'd0);
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end while (!imem_req && n < 10);
        chk("redirect_req", {31'd0, imem_req}, 32'd1);
        chk("redirect_addr", imem_addr, 32'h0000_0100);

        // Memory not ready for four cycles: request and address hold.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            chk("notready_req", {31'd0, imem_req}, 32'd1);
            chk("notready_addr", imem_addr, 32'h0000_0100);
        end
        lat_lo = 1; lat_hi = 3;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic with a reset pulse in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset();
                stray = 1'b1;
            end
            cycle(($urandom % 4) == 0, ($urandom % 20) == 0, $urandom, ($urandom % 10) < 7);
        end
        chk("liveness", {31'd0, (deliveries >= 40)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  one clock; all state rises on posedge clk.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  word-aligned fetch address, stable while imem_req && !imem_ready.
REQ-006 imem_ready  input  1  memory accepts request this cycle (imem_req && imem_ready = handshake).
REQ-007 imem_rvalid  input  1  response valid; exactly one response per accepted request, at least 1 cycle after acceptance.
REQ-008 imem_rdata  input  32  response instruction word.
REQ-009 stall  input  1  decode not consuming; hold IF/ID outputs.
REQ-010 flush  input  1  redirect from branch/jump resolution.
REQ-011 redirect_pc  input  32  new fetch target, sampled when flush=1.
REQ-012 if_instru  output  32  instruction to decode.
REQ-013 if_pc  output  32  PC of if_instru.
REQ-014 if_valid  output  1  if_instru/if_pc hold a real instruction.

Function
REQ-015 FSM states: REQ (imem_req=1), WAIT (one request outstanding, imem_req=0), HOLD (response buffered behind stall, imem_req=0).
REQ-016 REQ -> WAIT on handshake; fetch_pc <= fetch_pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); req_pc <= imem_addr.
REQ-017 WAIT, imem_rvalid, !stall -> IF/ID loads {imem_rdata, req_pc}, if_valid=1 next cycle; state -> REQ.
REQ-018 WAIT, imem_rvalid, stall -> response captured in 1-entry buffer; state -> HOLD.
REQ-019 HOLD, !stall -> IF/ID loads buffer next cycle, if_valid=1; state -> REQ.
REQ-020 Max one outstanding request; imem_req never 1 in WAIT or HOLD.
REQ-021 stall=1 holds if_instru, if_pc, if_valid unchanged.
REQ-022 flush=1 (priority over stall): fetch_pc <= {redirect_pc[31:2],2'b00}; if_valid <= 0; if_instru <= 32'h0000_0013 (NOP); buffer discarded; state -> REQ.
REQ-023 flush in WAIT: set discard flag; the pending imem_rvalid is dropped, never reaches IF/ID; no new request until it arrives.
REQ-024 flush and imem_rvalid same cycle in WAIT: response dropped, no discard flag set.
REQ-025 imem_rvalid while discard flag set: flag clears, state -> REQ next cycle.
REQ-026 if_valid=0 => if_instru = 32'h0000_0013.
REQ-027 Best-case throughput: one instruction per 2 cycles for 1-cycle memory (handshake cycle + response cycle).

Reset
REQ-028 On rst_n=0 asynchronously: fetch_pc=RESET_PC, state=REQ, discard=0, buffer empty, if_valid=0, if_instru=32'h0000_0013, if_pc=0, imem_req=0 while asserted.
REQ-029 First request issued the first cycle after rst_n deasserts, imem_addr=RESET_PC.
REQ-030 Reset mid-transaction abandons outstanding request; a late imem_rvalid after reset is ignored unless in WAIT.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN: defined -> adds output stall_cycles (32 bits), reset 0, +1 each cycle stall=1 && if_valid=1, saturates at 32'hFFFF_FFFF.
REQ-032 Not defined -> no stall_cycles port, no counter logic; other behaviour identical.

Verification
REQ-033 Reset release, imem_ready=1, 1-cycle rdata=32'h0050_0093 -> imem_addr=0, then if_pc=0, if_instru=32'h0050_0093, if_valid=1; next imem_addr=4.
REQ-034 stall=1 for 3 cycles while response 32'h0000_0113 arrives at PC 8 -> outputs hold prior instr; after stall drops, if_pc=8, if_instru=32'h0000_0113 next cycle.
REQ-035 flush with redirect_pc=32'h0000_0102 during WAIT -> outstanding response dropped, if_valid=0, if_instru=NOP; next imem_addr=32'h0000_0100.
REQ-036 imem_ready=0 for 4 cycles -> imem_req=1, imem_addr constant; fetch_pc unchanged until handshake.
REQ-037 RESET_PC=32'hFFFF_FFFC -> second imem_addr=0 (wrap).
REQ-038 FETCH_STALL_CNT_EN defined, stall=1 with if_valid=1 for 5 cycles -> stall_cycles=5; rst_n pulse mid-run -> 0.
